// File: rtl/xy_scan_sequencer.sv
// X/Y image ROM sequencer: draws a (base, len) segment point by point with a per-point dwell,
// blanking the beam across jumps and settle time, for a programmed number of passes.
module xy_scan_sequencer #(
    parameter int unsigned DEPTH    = 1231,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned DWELL_W  = 8,
    parameter int unsigned REPEAT_W = 4,
    parameter int unsigned SETTLE   = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [ADDR_W-1:0]   i_req_base,
    input  logic [ADDR_W-1:0]   i_req_len,
    input  logic [DWELL_W-1:0]  i_req_dwell,
    input  logic [REPEAT_W-1:0] i_req_repeat,
    input  logic                i_stop,
    output logic [ADDR_W-1:0]   o_rom_addr,
    output logic                o_blank,
    output logic                o_frame_start,
    output logic                o_done,
    output logic                o_err,
    output logic                o_busy
);

    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE - 1);
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StSettle, StDraw} state_e;

    state_e              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_len;
    logic [ADDR_W-1:0]   r_idx;
    logic [DWELL_W-1:0]  r_dwell;
    logic [DWELL_W-1:0]  r_dcnt;
    logic [REPEAT_W-1:0] r_repeat;
    logic [REPEAT_W-1:0] r_passes;
    logic [SET_W-1:0]    r_scnt;
    logic                r_blank;
    logic                r_frame_start;
    logic                r_done;
    logic                r_err;

    logic [ADDR_W:0] w_end;
    logic            w_reject;
    logic            w_last_pt;
    logic            w_final;

    // One extra bit so base + len cannot wrap before the bound check.
    assign w_end     = {1'b0, i_req_base} + {1'b0, i_req_len};
    assign w_reject  = (i_req_len == '0) || (w_end > DEPTH_W);
    assign w_last_pt = (r_idx == r_len - ADDR_W'(1)) && (r_dcnt == '0);
    assign w_final   = (r_repeat != '0) && (r_passes == REPEAT_W'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_addr        <= '0;
            r_base        <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            r_dwell       <= '0;
            r_dcnt        <= '0;
            r_repeat      <= '0;
            r_passes      <= '0;
            r_scnt        <= '0;
            r_blank       <= 1'b1;
            r_frame_start <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            // Blank follows DRAW one cycle late to line up with ROM read data.
            r_blank       <= (r_state != StDraw);
            unique case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_base   <= i_req_base;
                        r_len    <= i_req_len;
                        r_dwell  <= i_req_dwell;
                        r_repeat <= i_req_repeat;
                        if (w_reject) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state  <= StSettle;
                            r_addr   <= i_req_base;
                            r_scnt   <= SET_LOAD;
                            r_passes <= i_req_repeat;
                        end
                    end
                end
                StSettle: begin
                    r_idx <= '0;
                    if (r_scnt == '0) begin
                        r_state       <= StDraw;
                        r_frame_start <= 1'b1;
                        r_dcnt        <= r_dwell;
                    end else begin
                        r_scnt <= r_scnt - SET_W'(1);
                    end
                end
                StDraw: begin
                    if (w_last_pt) begin
                        if (r_repeat != '0) begin
                            r_passes <= r_passes - REPEAT_W'(1);
                        end
                        if (i_stop || w_final) begin
                            r_state <= StIdle;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StSettle;
                            r_addr  <= r_base;
                            r_scnt  <= SET_LOAD;
                        end
                    end else if (r_dcnt == '0) begin
                        r_idx  <= r_idx + ADDR_W'(1);
                        r_addr <= r_addr + ADDR_W'(1);
                        r_dcnt <= r_dwell;
                    end else begin
                        r_dcnt <= r_dcnt - DWELL_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_req_ready   = (r_state == StIdle) && !i_rst;
    assign o_busy        = (r_state != StIdle);
    assign o_rom_addr    = r_addr;
    assign o_blank       = r_blank;
    assign o_frame_start = r_frame_start;
    assign o_done        = r_done;
    assign o_err         = r_err;

endmodule

// File: doc/xy_scan_sequencer.md
# xy_scan_sequencer

Sequences the shared X/Y image ROM pair that feeds the vector-display DACs, in place of a free-running address counter. Several images sit back-to-back in the ROMs. A requester picks one as a (base, length) segment, plus a per-point dwell and a pass count. The block drives the ROM address, holds each point for the programmed dwell, blanks the beam during jumps and settling, and reports frame and completion events.

## Interface
- DEPTH, 1231: total ROM words; legal addresses are 0..DEPTH-1.
- ADDR_W, $clog2(DEPTH): address, base and length width.
- DWELL_W, 8: dwell field width.
- REPEAT_W, 4: pass-count field width.
- SETTLE, 4: blanked settle cycles after every jump to a segment base; must be ≥1.
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  segment request valid.
- o_req_ready  out  1  request accepted on a cycle where i_req_valid & o_req_ready.
- i_req_base  in  ADDR_W  first ROM address of the segment.
- i_req_len  in  ADDR_W  number of points (≥1).
- i_req_dwell  in  DWELL_W  clock cycles per point minus 1.
- i_req_repeat  in  REPEAT_W  number of passes; 0 means loop until stopped.
- i_stop  in  1  level: finish the current pass, then go idle.
- o_rom_addr  out  ADDR_W  address to both image ROMs (1-cycle read latency).
- o_blank  out  1  beam off; aligned with ROM output data, not the address.
- o_frame_start  out  1  1-cycle pulse at the start of each drawn pass.
- o_done  out  1  1-cycle pulse when the segment completes.
- o_err  out  1  1-cycle pulse when a request is rejected.
- o_busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, SETTLE, DRAW.
- IDLE
  - o_req_ready = 1.
  - On accept, base, len, dwell and repeat are latched; the block then validates the request.
  - Reject when len == 0 or base + len > DEPTH. The sum is computed at ADDR_W+1 bits. A rejected request pulses o_err on the next cycle and the block stays in IDLE.
  - A legal request moves to SETTLE with o_rom_addr = base.
- SETTLE
  - Settle counter loads SETTLE-1 and decrements; point index = 0; address held at base.
  - At count 0, move to DRAW and pulse o_frame_start on the first DRAW cycle.
- DRAW
  - Address = base + idx. The dwell counter loads dwell and decrements; at 0 the block advances idx by 1.
  - Last point (idx == len-1 and dwell count == 0):
    - Decrement passes_left when repeat ≠ 0.
    - If i_stop is sampled high on this cycle, or the last pass has completed: go to IDLE and pulse o_done. o_rom_addr holds its last value.
    - Otherwise: return to SETTLE with address = base (retrace).
- o_req_ready is low outside IDLE; requests are never queued.
- i_stop has no effect in IDLE or SETTLE except through its level at the last-point cycle. A stop raised during SETTLE still lets that pass draw fully.
- Address arithmetic never wraps past DEPTH-1; this is guaranteed by request validation.
- Reset mid-operation: the block returns to IDLE immediately and the segment is discarded.

## Timing
- Reset values: o_rom_addr = 0, o_blank = 1, o_frame_start = 0, o_done = 0, o_err = 0, o_busy = 0. o_req_ready = 1 from the first cycle after i_rst deasserts (0 while i_rst is high).
- Accept at edge E. From E+1 the block is in SETTLE with o_rom_addr = base. First DRAW cycle is E+1+SETTLE, and o_frame_start is high in that cycle.
- o_blank is registered from (state == DRAW). It therefore goes low one cycle after DRAW is entered and goes high one cycle after DRAW is left, tracking ROM data latency.
- Each point presents its address for exactly dwell+1 cycles.
- One pass = SETTLE + len·(dwell+1) cycles.
- o_done is high in the cycle the block is back in IDLE; o_req_ready is high in the same cycle, so back-to-back requests are allowed.
- Reject: accept at edge E, o_err high in cycle E+1, o_req_ready still high.

## Test plan
- Reset, then base=10, len=3, dwell=1, repeat=1:
  - o_rom_addr sequence: 10×4 (SETTLE), then 10,10,11,11,12,12.
  - o_frame_start pulses once; o_blank is low for exactly 6 cycles, delayed by 1.
  - o_done fires 1 cycle after the last 12.
- Rejections, each → o_err pulse, o_busy stays 0:
  - base=1230, len=2 (1232 > 1231).
  - len=0.
- Boundary request base=1228, len=3 → addresses 1228,1229,1230 are drawn, with no error and no wrap.
- repeat=3, len=2, dwell=0:
  - Exactly 3 o_frame_start pulses, each preceded by 4 blanked cycles at base.
  - o_blank returns high across each retrace; one o_done.
- repeat=0, len=4: runs continuously; i_stop raised mid-pass → the current pass completes all 4 points, then o_done and IDLE.
- i_rst asserted mid-DRAW:
  - Outputs take reset values asynchronously.
  - After release, o_req_ready = 1, and a new request draws from SETTLE normally.
